// File: rtl/sha_digest_uart_tx.sv
// ---------------------------------------------------------------------------
// sha_digest_uart_tx
//
// Takes a 256-bit SHA-256 digest and streams it out of an 8N1 UART as
// 64 lowercase ASCII hex characters, most significant nibble first,
// optionally followed by CR LF. A digest is accepted in one cycle and
// latched, so the source may change i_digest freely once it has been taken.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   SEND_CRLF     1 appends 0x0D 0x0A after the hex digits, 0 omits them
//
// Ports
//   clk             single clock, rising-edge active
//   rst             synchronous active-high reset
//   i_digest_valid  a digest is offered
//   i_digest        digest, bit 255 is the MSB of the first byte
//   o_digest_ready  block will take a digest this cycle (IDLE only)
//   o_uart_tx       registered serial line, idle high
//   o_busy          a frame is being transmitted
//   o_done          one-cycle pulse right after the last stop bit
// ---------------------------------------------------------------------------
module sha_digest_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned SEND_CRLF    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_digest_valid,
  input  logic [255:0] i_digest,
  output logic         o_digest_ready,
  output logic         o_uart_tx,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned NUM_CHARS = (SEND_CRLF != 0) ? 66 : 64;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [6:0]  CHAR_LAST = 7'(NUM_CHARS - 1);
  localparam logic [6:0]  CR_INDEX  = 7'd64;
  localparam logic [6:0]  LF_INDEX  = 7'd65;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [255:0]  digest_reg;
  logic [15:0]   baud_cnt;
  logic [2:0]    bit_idx;
  logic [6:0]    char_idx;
  logic          tx_reg;
  logic          done_reg;

  logic          accept;
  logic          bit_end;
  logic          last_char;
  logic [3:0]    nibble;
  logic [7:0]    cur_char;

  // Ready is gated by rst directly so that a digest offered while reset is
  // asserted is never taken, and so ready rises as soon as rst drops.
  assign o_digest_ready = (state == IDLE) && !rst;
  assign accept         = i_digest_valid && o_digest_ready;
  assign bit_end        = (baud_cnt == BAUD_LAST);
  assign last_char      = (char_idx == CHAR_LAST);

  assign o_busy    = (state != IDLE);
  assign o_uart_tx = tx_reg;
  assign o_done    = done_reg;

  // The digest register shifts left one nibble per finished character, so
  // the character being sent always comes from the top four bits. The two
  // trailing indices (64, 65) are the CR LF terminator when enabled.
  always_comb begin
    nibble   = digest_reg[255:252];
    cur_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                : (8'h57 + {4'h0, nibble});
    if (char_idx == CR_INDEX) begin
      cur_char = 8'h0D;
    end else if (char_idx == LF_INDEX) begin
      cur_char = 8'h0A;
    end
  end

  // State register of the transmit FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Every bit period ends when the baud counter reaches
  // its last count; the FSM only moves on those boundaries.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx == 3'd7)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = last_char ? IDLE : START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, serial line and done pulse. The line is registered, so the
  // value for each new bit is loaded on the same edge the FSM enters that
  // bit; this makes the start bit appear the cycle after acceptance and
  // leaves no gap between a stop bit and the next start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          char_idx <= '0;
          tx_reg   <= accept ? 1'b0 : 1'b1;
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= cur_char[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_reg <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_reg  <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (last_char) begin
              char_idx <= '0;
              tx_reg   <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              char_idx <= char_idx + 7'd1;
              tx_reg   <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          baud_cnt <= '0;
          tx_reg   <= 1'b1;
        end
      endcase
    end
  end

  // Digest holding register. It has no reset: its contents only matter
  // after an acceptance, which always reloads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      digest_reg <= i_digest;
    end else if ((state == STOP) && bit_end && !last_char) begin
      digest_reg <= digest_reg << 4;
    end
  end

endmodule

// File: tb/tb_sha_digest_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_sha_digest_uart_tx
//
// Three instances of sha_digest_uart_tx share one clock and reset:
//   inst 0: CLKS_PER_BIT=4, CRLF on  (66 chars)
//   inst 1: CLKS_PER_BIT=4, CRLF off (64 chars)
//   inst 2: CLKS_PER_BIT=2, CRLF on  (66 chars)
// Expected line activity is built from the digest text and the 8N1 rules.
// ---------------------------------------------------------------------------
module tb_sha_digest_uart_tx;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk;
  logic         rst;
  logic [2:0]   valid;
  logic [255:0] dig [3];
  logic [2:0]   ready;
  logic [2:0]   tx;
  logic [2:0]   busy;
  logic [2:0]   done;

  int cpb    [3] = '{4, 4, 2};
  int nchars [3] = '{66, 64, 66};

  int vectors     = 0;
  int miscompares = 0;

  sha_digest_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(1)) dut0 (
    .clk(clk), .rst(rst), .i_digest_valid(valid[0]), .i_digest(dig[0]),
    .o_digest_ready(ready[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  sha_digest_uart_tx #(.CLKS_PER_BIT(4), .SEND_CRLF(0)) dut1 (
    .clk(clk), .rst(rst), .i_digest_valid(valid[1]), .i_digest(dig[1]),
    .o_digest_ready(ready[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  sha_digest_uart_tx #(.CLKS_PER_BIT(2), .SEND_CRLF(1)) dut2 (
    .clk(clk), .rst(rst), .i_digest_valid(valid[2]), .i_digest(dig[2]),
    .o_digest_ready(ready[2]), .o_uart_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2])
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] randDigest();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Character idx of the frame: hex text of the digest, then CR LF.
  function automatic logic [7:0] expChar(input logic [255:0] d, input int idx);
    string s;
    s = $sformatf("%064h", d);
    if (idx < 64) return s[idx];
    else if (idx == 64) return 8'h0d;
    else return 8'h0a;
  endfunction

  // Line level during bit slot bitpos (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic expBit(input logic [7:0] ch, input int bitpos);
    if (bitpos == 0) return 1'b0;
    else if (bitpos == 9) return 1'b1;
    else return ch[bitpos - 1];
  endfunction

  // Watches a whole frame starting at the start-bit cycle (called at a
  // negedge) and leaves the caller at the negedge of the o_done cycle.
  task automatic captureFrame(input int inst, input logic [255:0] d,
                              input bit release_valid, input int pulse_at,
                              input logic [255:0] pulse_digest,
                              output logic [7:0] first_dec);
    int c, n, per, cyc, busy_low, done_hi;
    logic [63:0] obs, expw;
    logic [7:0]  ch;
    c = cpb[inst];
    n = nchars[inst];
    per = 10 * c;
    busy_low = 0;
    done_hi = 0;
    first_dec = 8'h00;
    for (int i = 0; i < n; i++) begin
      obs = '0;
      expw = '0;
      ch = expChar(d, i);
      for (int k = 0; k < per; k++) begin
        cyc = i * per + k;
        obs[k] = tx[inst];
        expw[k] = expBit(ch, k / c);
        if (!busy[inst]) busy_low++;
        if (done[inst]) done_hi++;
        if (cyc == 0 && release_valid) begin
          valid[inst] = 1'b0;
          dig[inst] = randDigest();
        end
        if (cyc == pulse_at) begin
          valid[inst] = 1'b1;
          dig[inst] = pulse_digest;
        end
        if (pulse_at >= 0 && cyc == pulse_at + 1) valid[inst] = 1'b0;
        @(negedge clk);
      end
      checkOutput($sformatf("wave_i%0d_c%0d", inst, i), obs, expw);
      if (i == 0) begin
        for (int j = 0; j < 8; j++) first_dec[j] = obs[(j + 1) * c];
      end
    end
    checkOutput($sformatf("busy_in_frame_i%0d", inst), 64'(busy_low), 64'd0);
    checkOutput($sformatf("done_early_i%0d", inst), 64'(done_hi), 64'd0);
    checkOutput($sformatf("done_pulse_i%0d", inst), 64'(done[inst]), 64'd1);
    checkOutput($sformatf("done_busy_i%0d", inst), 64'(busy[inst]), 64'd0);
    checkOutput($sformatf("done_ready_i%0d", inst), 64'(ready[inst]), 64'd1);
    checkOutput($sformatf("done_tx_i%0d", inst), 64'(tx[inst]), 64'd1);
  endtask

  // Offers a digest for one cycle and checks the resulting frame.
  task automatic applyStimulus(input int inst, input logic [255:0] d, output logic [7:0] first_dec);
    valid[inst] = 1'b1;
    dig[inst] = d;
    @(negedge clk);
    captureFrame(inst, d, 1'b1, -1, '0, first_dec);
  endtask

  // Expects the instance to sit idle (line high, not busy, no done).
  task automatic checkIdle(input int inst, input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx[inst] !== 1'b1 || busy[inst] !== 1'b0 || done[inst] !== 1'b0) bad++;
    end
    checkOutput(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [7:0]   fd;
    logic [255:0] d1, d2;

    rst = 1'b1;
    valid = '0;
    for (int i = 0; i < 3; i++) dig[i] = '0;

    // Reset held for two cycles.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready_low", 64'(ready[0]), 64'd0);
    checkOutput("rst_tx", 64'(tx[0]), 64'd1);
    checkOutput("rst_busy", 64'(busy[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 64'(ready), 64'h7);
    checkOutput("post_rst_tx", 64'(tx), 64'h7);
    checkOutput("post_rst_busy", 64'(busy), 64'h0);
    checkOutput("post_rst_done", 64'(done), 64'h0);

    // Known SHA-256("abc") digest.
    applyStimulus(0, ABC_DIGEST, fd);
    checkOutput("abc_first_char", 64'(fd), 64'h62);
    checkIdle(0, 20, "idle_after_abc");

    // Extremes.
    applyStimulus(0, '0, fd);
    checkOutput("zero_first_char", 64'(fd), 64'h30);
    checkIdle(0, 10, "idle_after_zero");
    applyStimulus(0, '1, fd);
    checkOutput("ones_first_char", 64'(fd), 64'h66);
    checkIdle(0, 10, "idle_after_ones");

    // No CR LF.
    applyStimulus(1, randDigest(), fd);
    checkIdle(1, 10, "idle_after_nocrlf_rand");
    applyStimulus(1, '1, fd);
    checkIdle(1, 10, "idle_after_nocrlf_ones");

    // A second digest pulsed mid-frame is ignored.
    d1 = randDigest();
    d2 = randDigest();
    valid[0] = 1'b1;
    dig[0] = d1;
    @(negedge clk);
    captureFrame(0, d1, 1'b1, 500, d2, fd);
    checkIdle(0, 100, "no_second_frame");

    // Random digests on both baud settings.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(0, randDigest(), fd);
      checkIdle(0, 5, $sformatf("idle_rand0_%0d", r));
    end
    for (int r = 0; r < 2; r++) begin
      applyStimulus(2, randDigest(), fd);
      checkIdle(2, 5, $sformatf("idle_rand2_%0d", r));
    end

    // Valid held high across two digests: back-to-back frames.
    for (int inst = 0; inst < 3; inst += 2) begin
      d1 = randDigest();
      d2 = randDigest();
      valid[inst] = 1'b1;
      dig[inst] = d1;
      @(negedge clk);
      dig[inst] = d2;
      captureFrame(inst, d1, 1'b0, -1, '0, fd);
      @(negedge clk);
      captureFrame(inst, d2, 1'b1, -1, '0, fd);
      checkIdle(inst, 20, $sformatf("idle_after_b2b_i%0d", inst));
    end

    // Reset during character 10 aborts the frame.
    valid[0] = 1'b1;
    dig[0] = randDigest();
    @(negedge clk);
    valid[0] = 1'b0;
    for (int i = 0; i < 10 * 40 + 17; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_tx", 64'(tx[0]), 64'd1);
    checkOutput("abort_busy", 64'(busy[0]), 64'd0);
    checkOutput("abort_done", 64'(done[0]), 64'd0);
    checkOutput("abort_ready_in_rst", 64'(ready[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready_after", 64'(ready[0]), 64'd1);
    checkIdle(0, 50, "idle_after_abort");
    applyStimulus(0, randDigest(), fd);
    checkIdle(0, 5, "idle_after_recovery");

    // Reset wins over a simultaneous valid.
    rst = 1'b1;
    valid[0] = 1'b1;
    dig[0] = randDigest();
    @(negedge clk);
    rst = 1'b0;
    valid[0] = 1'b0;
    checkIdle(0, 20, "rst_beats_valid");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sha_digest_uart_tx.md
SHA_DIGEST_UART_TX -- requirements
Module: sha_digest_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter SEND_CRLF, default 1; 1 appends 0x0D 0x0A after the hex digits, 0 sends the hex digits only.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_digest_valid  input  1  digest offered to the block.
REQ-006 i_digest  input  256  SHA-256 digest; bit 255 is the MSB of the first digest byte.
REQ-007 o_digest_ready  output  1  block accepts a digest this cycle.
REQ-008 o_uart_tx  output  1  8N1 serial line, idle high.
REQ-009 o_busy  output  1  a transmission is in progress.
REQ-010 o_done  output  1  single-cycle pulse when a frame has fully finished.

Function
REQ-011 The block SHALL accept a digest when i_digest_valid and o_digest_ready are both high at a rising edge, and latch all 256 bits into an internal register in that cycle.
REQ-012 o_digest_ready SHALL be high only in state IDLE; i_digest_valid outside IDLE SHALL be ignored and not queued.
REQ-013 Changes on i_digest after acceptance SHALL NOT affect the frame in progress.
REQ-014 The frame SHALL be 64 ASCII hex characters, most significant nibble first (i_digest[255:252] first), using lowercase letters: 0-9 -> 0x30-0x39, a-f -> 0x61-0x66.
REQ-015 With SEND_CRLF=1 the frame SHALL be followed by 0x0D then 0x0A, giving N=66 characters; with SEND_CRLF=0, N=64.
REQ-016 Each character SHALL be sent as 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1), each bit held exactly CLKS_PER_BIT cycles.
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP with these transitions: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->START if characters remain, else STOP->IDLE.
REQ-018 The start bit SHALL appear on o_uart_tx in the cycle after the acceptance cycle, since o_uart_tx is registered.
REQ-019 There SHALL be no idle gap between consecutive characters of one frame.
REQ-020 A frame SHALL occupy exactly N*10*CLKS_PER_BIT cycles of o_uart_tx activity.
REQ-021 o_done SHALL pulse high for exactly one cycle, in the first cycle after the last stop bit completes.
REQ-022 In the o_done cycle, o_busy SHALL be 0 and o_digest_ready SHALL be 1, so back-to-back acceptance is possible with a one-cycle idle-high gap.
REQ-023 o_busy SHALL be high from the cycle after acceptance through the last stop-bit cycle.
REQ-024 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL cover 0..7; the character index SHALL cover 0..N-1 with no wrap into a second frame.
REQ-025 o_uart_tx SHALL remain high in IDLE.

Reset
REQ-026 While rst is high at a rising edge, the block SHALL set the state to IDLE, clear all counters, drive o_uart_tx=1, o_busy=0 and o_done=0, and set o_digest_ready=0 during reset; o_digest_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 rst asserted mid-frame SHALL abort the frame: o_uart_tx goes high from the next cycle, no o_done pulse is generated, and the partial frame is discarded.
REQ-028 rst SHALL take priority over a simultaneous i_digest_valid; that digest SHALL NOT be accepted.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-029 Reset: rst high 2 cycles, then low -> o_uart_tx=1, o_busy=0, o_done=0, o_digest_ready=1.
REQ-030 SHA-256("abc") digest ba7816bf...f20015ad -> decoded bytes are "ba7816bf...f20015ad" followed by 0x0D 0x0A; first character 0x62; o_done pulses 66*40=2640 cycles after the start-bit cycle.
REQ-031 Extremes -> all-zero digest gives 64x 0x30 plus CRLF; all-ones digest gives 64x 0x66 plus CRLF; with SEND_CRLF=0 exactly 64 characters and o_done after 2560 cycles.
REQ-032 A second digest with i_digest_valid pulsed mid-frame -> it is ignored, the first frame is unaltered, and no second frame is sent.
REQ-033 rst asserted during character 10 -> o_uart_tx=1 the next cycle, no o_done pulse, and a new digest is accepted normally afterwards.
REQ-034 i_digest_valid held high with two digests -> the second is accepted in the o_done cycle and its start bit begins after exactly one idle-high cycle; CLKS_PER_BIT=2 boundary also passes.
